// File: rtl/alu_pkg.sv
// Shared opcode encodings, default datapath width and sizing helper for the ALU slice.
package alu_pkg;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;
    localparam logic [2:0] ALU_SLT      = 3'b111;

    localparam int unsigned ALU_DATA_W = 64;

    // Number of 4-input OR stages needed to reduce n bits to one.
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned levels;
        int unsigned remaining;
        levels    = 0;
        remaining = n;
        while (remaining > 1) begin
            remaining = (remaining + 3) / 4;
            levels    = levels + 1;
        end
        return levels;
    endfunction

endpackage

// File: rtl/alu_bit_slice_cell.sv
// One-bit ALU slice: full adder with optional B inversion plus the bitwise logic ops.
import alu_pkg::*;

module alu_bit_slice_cell (
    input  logic       a,
    input  logic       b,
    input  logic       carry_prev,
    input  logic [2:0] cntrl,
    output logic       result,
    output logic       carry
);

    logic b_eff;
    logic sum;

    assign b_eff = b ^ cntrl[0];
    assign sum   = a ^ b_eff ^ carry_prev;
    assign carry = (a & b_eff) | (carry_prev & (a ^ b_eff));

    always_comb begin
        result = 1'b0;
        case (cntrl)
            ALU_PASS_B:            result = b;
            ALU_ADD, ALU_SUBTRACT: result = sum;
            ALU_AND:               result = a & b;
            ALU_OR:                result = a | b;
            ALU_XOR:               result = a ^ b;
            default:               result = 1'b0;
        endcase
    end

endmodule

// File: rtl/is_zero.sv
// All-zero detector: tree of 4-input OR stages followed by a final inversion.
import alu_pkg::*;

module is_zero #(
    parameter int unsigned WIDTH = ALU_DATA_W
) (
    input  logic [WIDTH-1:0] bits,
    output logic             zero
);

    localparam int unsigned LEVELS = clog4(WIDTH);

    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    int unsigned      n;

    // Each pass ORs groups of four live nodes; n tracks how many nodes remain live.
    always_comb begin
        cur = bits;
        nxt = '0;
        n   = WIDTH;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            nxt = '0;
            for (int unsigned j = 0; j < WIDTH; j++) begin
                for (int unsigned k = 0; k < 4; k++) begin
                    if ((j * 4 + k) < n) begin
                        nxt[j] = nxt[j] | cur[j * 4 + k];
                    end
                end
            end
            cur = nxt;
            n   = (n + 3) / 4;
        end
    end

    assign zero = ~cur[0];

endmodule

// File: rtl/alu_bit_slice.sv
// Registered ripple-carry ALU built from 1-bit slices; opcode 111 becomes
// signed set-less-than when ALU_SLT_EN is defined, otherwise it yields zero.
import alu_pkg::*;

module alu_bit_slice #(
    parameter int unsigned WIDTH = ALU_DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    logic [WIDTH-1:0] cout;
    logic [WIDTH-1:0] slice_res;
    logic [WIDTH-1:0] res_next;
    logic             zero_next;
    logic             arith;
    logic             ovf_raw;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic carry_prev;
        if (i == 0) begin : g_first
            assign carry_prev = cntrl[0];
        end else begin : g_rest
            assign carry_prev = cout[i-1];
        end
        alu_bit_slice_cell u_cell (
            .a          (A[i]),
            .b          (B[i]),
            .carry_prev (carry_prev),
            .cntrl      (cntrl),
            .result     (slice_res[i]),
            .carry      (cout[i])
        );
    end

    assign arith   = (cntrl == ALU_ADD) || (cntrl == ALU_SUBTRACT);
    assign ovf_raw = cout[WIDTH-1] ^ cout[WIDTH-2];

`ifdef ALU_SLT_EN
    logic sub_msb;
    // Opcode 111 has cntrl[0]=1, so the chain already runs as A + ~B + 1.
    assign sub_msb = A[WIDTH-1] ^ ~B[WIDTH-1] ^ cout[WIDTH-2];

    always_comb begin
        res_next = slice_res;
        if (cntrl == ALU_SLT) begin
            res_next    = '0;
            res_next[0] = sub_msb ^ ovf_raw;
        end
    end
`else
    assign res_next = slice_res;
`endif

    is_zero #(.WIDTH(WIDTH)) u_is_zero (
        .bits (res_next),
        .zero (zero_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            result    <= res_next;
            negative  <= res_next[WIDTH-1];
            zero      <= zero_next;
            overflow  <= arith ? ovf_raw : 1'b0;
            carry_out <= arith ? cout[WIDTH-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_bit_slice.sv
// Self-checking bench for alu_bit_slice: directed corner vectors plus random ops
// compared against a plain-arithmetic reference model one cycle later.
module tb_alu_bit_slice;

    logic        clk;
    logic        reset;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic        pend;
    logic [63:0] exp_res;
    logic [3:0]  exp_flags;
    string       exp_tag;

    alu_bit_slice #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: flags packed as {negative, zero, overflow, carry_out}.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op,
                         output logic [63:0] r, output logic [3:0] f);
        logic [64:0] full;
        logic        v;
        logic        c;
        v = 1'b0;
        c = 1'b0;
        r = '0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[63:0];
                c = full[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                full = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = full[63:0];
                c = full[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
`ifdef ALU_SLT_EN
            3'b111: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
`endif
            default: r = '0;
        endcase
        f = {r[63], (r == 64'd0), v, c};
    endtask

    task automatic check_pending();
        if (pend) begin
            check({exp_tag, ".result"}, result, exp_res);
            check({exp_tag, ".flags"}, {60'd0, negative, zero, overflow, carry_out}, {60'd0, exp_flags});
        end
    endtask

    // Inputs change on the falling edge; the previous vector's outputs are checked there too.
    task automatic step(input string tag, input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        logic [63:0] r;
        logic [3:0]  f;
        @(negedge clk);
        check_pending();
        A     = a;
        B     = b;
        cntrl = op;
        model(a, b, op, r, f);
        exp_res   = r;
        exp_flags = f;
        exp_tag   = tag;
        pend      = 1'b1;
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        logic [2:0]  rop;
        n_cmp = 0;
        n_bad = 0;
        pend  = 1'b0;

        reset = 1'b1;
        A     = 64'd5;
        B     = 64'd3;
        cntrl = 3'b010;
        @(posedge clk);
        #1;
        check("reset.result", result, 64'd0);
        check("reset.flags", {60'd0, negative, zero, overflow, carry_out}, 64'b0100);
        reset = 1'b0;

        step("passb", 64'h1234_5678_9abc_def0, 64'h8000_0000_0000_0001, 3'b000);
        step("passb0", 64'hdead_beef_0000_0001, 64'd0, 3'b000);
        step("add_ovf", 64'h7fff_ffff_ffff_ffff, 64'd1, 3'b010);
        step("add_wrap", 64'hffff_ffff_ffff_ffff, 64'd1, 3'b010);
        step("add_negovf", 64'h8000_0000_0000_0000, 64'hffff_ffff_ffff_ffff, 3'b010);
        step("sub_4_2", 64'd4, 64'd2, 3'b011);
        step("sub_borrow", 64'd4, 64'hffff_ffff_ffff_fffe, 3'b011);
        step("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 3'b011);
        step("sub_neg", 64'd2, 64'd4, 3'b011);
        step("and", 64'd4, 64'd3, 3'b100);
        step("or", 64'd4, 64'd3, 3'b101);
        step("xor_same", 64'd12, 64'd12, 3'b110);
        step("xor", 64'd3, 64'd5, 3'b110);
        step("op001", 64'hffff_0000_ffff_0000, 64'h1111_2222_3333_4444, 3'b001);
        step("op111", 64'hffff_ffff_ffff_ffff, 64'd1, 3'b111);
        step("op111b", 64'd1, 64'hffff_ffff_ffff_ffff, 3'b111);
        step("b2b_add", 64'd100, 64'd23, 3'b010);
        step("b2b_sub", 64'd100, 64'd23, 3'b011);
        step("b2b_xor", 64'd100, 64'd23, 3'b110);

        for (int i = 0; i < 300; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: ra = 64'h8000_0000_0000_0000;
                2: rb = 64'hffff_ffff_ffff_ffff;
                default: ;
            endcase
            step("rand", ra, rb, rop);
        end

        // Reset arriving alongside a live operation must win.
        @(negedge clk);
        check_pending();
        pend  = 1'b0;
        reset = 1'b1;
        A     = 64'h7fff_ffff_ffff_ffff;
        B     = 64'd1;
        cntrl = 3'b010;
        @(posedge clk);
        #1;
        check("reset2.result", result, 64'd0);
        check("reset2.flags", {60'd0, negative, zero, overflow, carry_out}, 64'b0100);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_bit_slice.md
Name: alu_bit_slice

Overview:
- Registered N-bit ALU datapath built as a ripple chain of 1-bit ALU slices plus an all-zero detector on the result.
- Performs pass-B, add, subtract, AND, OR and XOR, and produces negative, zero, overflow and carry flags.
- Sits in the execute stage of the pipelined CPU.
- Result and flags are captured in an output register, so the block has one cycle of latency.

Parameters:
- WIDTH, 64, datapath width in bits; must be ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all outputs.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- cntrl  input  3  operation select.
- result  output  WIDTH  registered operation result.
- negative  output  1  registered copy of result[WIDTH-1].
- zero  output  1  registered flag, 1 when result is all zeros.
- overflow  output  1  registered two's-complement overflow flag (add/sub only).
- carry_out  output  1  registered carry out of the MSB (add/sub only).

Behaviour:
- Opcodes:
  - 000: result = B.
  - 010: result = A + B.
  - 011: result = A - B, computed as A + ~B + 1.
  - 100: result = A & B.
  - 101: result = A | B.
  - 110: result = A ^ B.
  - 001 and 111: result = 0 (see Optional Feature for 111).
- Slice i inputs: a=A[i], b=B[i], carry-in, cntrl. Slice i outputs: result bit and carry-out.
  - The slice inverts b when cntrl[0]=1.
  - Slice 0 carry-in = cntrl[0].
  - Slice i carry-in = carry-out of slice i-1.
- Combinational flags, computed before the output register:
  - overflow = Cout[WIDTH-1] XOR Cout[WIDTH-2].
  - carry_out = Cout[WIDTH-1]. For subtract, carry_out=1 means no borrow (A ≥ B unsigned).
  - For opcodes other than 010 and 011, overflow and carry_out are forced to 0.
  - negative = result MSB.
  - zero = NOR of all result bits, from the is_zero sub-module.
- Timing:
  - Every rising clk edge with reset=0 registers result and all four flags from the current A, B, cntrl.
  - Outputs reflect the inputs of the previous edge; there is no handshake and no enable.
- Reset: on a rising edge with reset=1, result=0, negative=0, overflow=0, carry_out=0, and zero=1 (consistent with result=0).
  - Reset has priority over a concurrent operation.
  - Inputs presented during the reset cycle are discarded.
- Wrap-around: results are modulo 2^WIDTH; the carry out of the MSB is never added back.

Optional Feature:
- Macro ALU_SLT_EN.
- When defined, opcode 111 is signed set-less-than:
  - result = {WIDTH-1 zeros, (A - B negative) XOR overflow}, using the subtract carry chain (B inverted, carry-in 1).
  - overflow and carry_out are forced to 0.
  - zero and negative follow the result.
- When not defined, opcode 111 yields result=0 and zero=1, with the other flags 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams ALU_PASS_B=3'b000, ALU_ADD=3'b010, ALU_SUBTRACT=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110, ALU_SLT=3'b111;
  - the ALU_DATA_W=64 constant.
- Sub-modules:
  - A 1-bit slice cell, instantiated WIDTH times in a generate loop.
  - is_zero, a WIDTH-input NOR tree using 4-input OR stages followed by a final inversion.

Test Plan:
- Reset: hold reset=1 for one edge with A=5, B=3, cntrl=010 -> result=0, zero=1, negative=0, overflow=0, carry_out=0.
- PASS_B with random A and B -> one cycle later result=B, negative=B[63], zero=(B==0).
- ADD:
  - 7FFF_FFFF_FFFF_FFFF+1 -> 8000_0000_0000_0000, overflow=1, negative=1.
  - FFFF_FFFF_FFFF_FFFF+1 -> 0, carry_out=1, zero=1, overflow=0.
  - 8000_0000_0000_0000+FFFF_FFFF_FFFF_FFFF -> 7FFF_FFFF_FFFF_FFFF, overflow=1.
- SUBTRACT:
  - 4-2 -> 2, carry_out=1.
  - 4-FFFF_FFFF_FFFF_FFFE -> 6, carry_out=0.
  - 8000_0000_0000_0000-1 -> 7FFF_FFFF_FFFF_FFFF, overflow=1.
  - 2-4 -> FFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0.
- Logic ops:
  - AND 4&3 -> 0, zero=1.
  - OR 4|3 -> 7.
  - XOR 12^12 -> 0, zero=1.
  - XOR 3^5 -> 6.
  - For all of these, overflow=0 and carry_out=0.
- Back-to-back: change the opcode every cycle (ADD, SUB, XOR) -> each output matches the previous cycle's inputs with no bubbles. With ALU_SLT_EN defined, opcode 111 with A=FFFF_FFFF_FFFF_FFFF and B=1 -> result=1.
